adc_spi_responder: RTL and testbench

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_resp_pkg.sv | 17 +
 rtl/spi_pin_sync.sv | 34 +++
 rtl/adc_spi_responder.sv | 158 +++++++++++++++
 tb/tb_adc_spi_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/adc_resp_pkg.sv
// Shared constants and FSM state type for the ADC SPI responder.
package adc_resp_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CHAN_MSB   = 13;
    localparam int unsigned CHAN_LSB   = 11;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned CHAN_W     = CHAN_MSB - CHAN_LSB + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with edge detection.
// The chain and the edge-history flop preset to RST_VAL so reset never
// manufactures an edge on a pin that sits at its idle level.
module spi_pin_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Synchronizer chain plus one flop of history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign q      = chain[STAGES-1];
    assign rise_c = chain[STAGES-1] & ~prev;
    assign fall_c = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave emulating a multi-channel 12-bit ADC (SCLK idle high, data driven
// on falling edges, sampled on rising edges). Each 16-bit frame returns the
// sample of the channel selected by the previous frame's command.
// Optional build macro: ADC_RESP_ERRCHK_EN -- reject commands with reserved
// bits set or an out-of-range channel (frame_err pulses, cur_chan holds).
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int unsigned NCHAN       = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sclk,
    input  logic                      cs_n,
    input  logic                      mosi,
    output logic                      miso,
    input  logic [NCHAN*DATA_BITS-1:0] samples,
    output logic [2:0]                cur_chan,
    output logic                      frame_done,
    output logic                      frame_err
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(sclk),
        .q(sclk_s), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(cs_n),
        .q(cs_s), .rise_c(cs_rise), .fall_c(cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .q(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
    );

    state_t                 state, state_d;
    logic [FRAME_BITS-1:0]  tx_shift, tx_d;
    logic [FRAME_BITS-1:0]  rx_shift, rx_d;
    logic [CNT_W-1:0]       bit_cnt, cnt_d;
    logic                   miso_d, done_d, err_d;
    logic [2:0]             chan_d;
    logic [DATA_BITS-1:0]   sel_sample;
    logic [CHAN_W-1:0]      rx_chan;
    logic                   cmd_bad;

    // Sample of the currently selected channel; unpopulated channels read zero.
    always_comb begin
        sel_sample = '0;
        for (int k = 0; k < int'(NCHAN); k++) begin
            if (cur_chan == 3'(k)) begin
                sel_sample = samples[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // State register and all FSM-owned datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            miso       <= 1'b0;
            cur_chan   <= 3'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            tx_shift   <= tx_d;
            rx_shift   <= rx_d;
            bit_cnt    <= cnt_d;
            miso       <= miso_d;
            cur_chan   <= chan_d;
            frame_done <= done_d;
            frame_err  <= err_d;
        end
    end

    // Next-state and next-datapath logic; cs_n rising outranks any sclk edge.
    always_comb begin
        state_d = state;
        tx_d    = tx_shift;
        rx_d    = rx_shift;
        cnt_d   = bit_cnt;
        miso_d  = miso;
        chan_d  = cur_chan;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rx_chan = '0;
        cmd_bad = 1'b0;

        case (state)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d = SHIFT;
                    tx_d    = {4'b0000, sel_sample};
                    cnt_d   = '0;
                    miso_d  = 1'b0;
                end
            end

            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    miso_d  = 1'b0;
                end else if (sclk_rise) begin
                    rx_d  = {rx_shift[FRAME_BITS-2:0], mosi_s};
                    cnt_d = CNT_W'(bit_cnt + 1'b1);
                    if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        miso_d  = 1'b0;
                        rx_chan = rx_d[CHAN_MSB:CHAN_LSB];
`ifdef ADC_RESP_ERRCHK_EN
                        cmd_bad = (rx_d[FRAME_BITS-1:CHAN_MSB+1] != '0) ||
                                  (rx_d[CHAN_LSB-1:0] != '0) ||
                                  (32'(rx_chan) >= 32'(NCHAN));
`else
                        cmd_bad = 1'b0;
`endif
                        if (cmd_bad) begin
                            err_d = 1'b1;
                        end else begin
                            chan_d = 3'(rx_chan);
                        end
                    end
                end else if (sclk_fall && (bit_cnt != '0)) begin
                    // The first falling edge precedes the first sample point,
                    // so the MSB stays on the line until a bit has been taken.
                    tx_d   = {tx_shift[FRAME_BITS-2:0], 1'b0};
                    miso_d = tx_shift[FRAME_BITS-2];
                end
            end

            DONE: begin
                miso_d = 1'b0;
                if (cs_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: frame data, channel selection,
// short frames, mid-frame sample changes, command checking and reset abort.
module tb_adc_spi_responder;

    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [23:0] samples;
    logic [2:0]  cur_chan;
    logic        frame_done;
    logic        frame_err;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int exp_done = 0;
    int exp_err = 0;
    logic [15:0] rx;

    adc_spi_responder #(.NCHAN(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .samples(samples), .cur_chan(cur_chan),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        sclk = 1'b0;
        mosi = b;
        #(HALF);
        m = miso;
        sclk = 1'b1;
        #(HALF);
    endtask

    task automatic do_frame(input logic [15:0] cmd, input int nbits, input int chg_at,
                            output logic [15:0] r);
        logic m;
        r = '0;
        cs_n = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) samples[11:0] = 12'hFFF;
            spi_bit(cmd[15-i], m);
            r[15-i] = m;
        end
        cs_n = 1'b1;
        mosi = 1'b0;
        #(4*HALF);
    endtask

    initial begin
        logic m;
        reset   = 1'b1;
        sclk    = 1'b1;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        samples = {12'hABC, 12'h123};
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_cur_chan", 16'(cur_chan), 16'h0);
        check("rst_miso", 16'(miso), 16'h0);
        check("rst_done", 16'(frame_done), 16'h0);
        check("rst_err", 16'(frame_err), 16'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Channel 1 requested; this frame still returns channel 0.
        do_frame(16'h0800, 16, -1, rx);
        exp_done++;
        check("f1_data", rx, 16'h0123);
        check("f1_chan", 16'(cur_chan), 16'h1);
        check("f1_done", 16'(done_cnt), 16'(exp_done));
        check("f1_err", 16'(err_cnt), 16'(exp_err));
        check("idle_miso", 16'(miso), 16'h0);

        // Channel 0 requested; returns channel 1 selected previously.
        do_frame(16'h0000, 16, -1, rx);
        exp_done++;
        check("f2_data", rx, 16'h0ABC);
        check("f2_chan", 16'(cur_chan), 16'h0);
        check("f2_done", 16'(done_cnt), 16'(exp_done));

        // Short frame: cs_n released after 9 clocks.
        do_frame(16'h0800, 9, -1, rx);
        exp_err++;
        check("short_err", 16'(err_cnt), 16'(exp_err));
        check("short_done", 16'(done_cnt), 16'(exp_done));
        check("short_chan", 16'(cur_chan), 16'h0);

        // Sample changes mid-frame must not disturb the frame in flight.
        do_frame(16'h0000, 16, 4, rx);
        exp_done++;
        check("midchg_data", rx, 16'h0123);
        check("midchg_done", 16'(done_cnt), 16'(exp_done));
        samples[11:0] = 12'h123;

        // Channel 7 command (out of range for NCHAN=2).
        do_frame(16'h3800, 16, -1, rx);
        exp_done++;
        check("ch7_data", rx, 16'h0123);
`ifdef ADC_RESP_ERRCHK_EN
        exp_err++;
        check("ch7_chan", 16'(cur_chan), 16'h0);
`else
        check("ch7_chan", 16'(cur_chan), 16'h7);
`endif
        check("ch7_done", 16'(done_cnt), 16'(exp_done));
        check("ch7_err", 16'(err_cnt), 16'(exp_err));

        do_frame(16'h0800, 16, -1, rx);
        exp_done++;
`ifdef ADC_RESP_ERRCHK_EN
        check("after7_data", rx, 16'h0123);
`else
        check("after7_data", rx, 16'h0000);
`endif
        check("after7_chan", 16'(cur_chan), 16'h1);

        // Reset mid-frame at bit 8: no error pulse, channel back to 0.
        cs_n = 1'b0;
        #(HALF);
        for (int i = 0; i < 8; i++) spi_bit(1'b0, m);
        reset = 1'b1;
        cs_n  = 1'b1;
        sclk  = 1'b1;
        mosi  = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrst_chan", 16'(cur_chan), 16'h0);
        check("midrst_miso", 16'(miso), 16'h0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_err", 16'(err_cnt), 16'(exp_err));
        check("midrst_done", 16'(done_cnt), 16'(exp_done));

        do_frame(16'h0800, 16, -1, rx);
        exp_done++;
        check("clean_data", rx, 16'h0123);
        check("clean_chan", 16'(cur_chan), 16'h1);
        check("clean_err", 16'(err_cnt), 16'(exp_err));
        check("clean_done", 16'(done_cnt), 16'(exp_done));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
